c3s4_layer_sequencer: RTL and testbench
=======================================

// Module: c3s4_layer_sequencer
// PURPOSE
//  Top-level controller for the C3S4 conv/pool layer. On start, loads the per-feature-map
//  kernel RAMs (C3_kernel_ram x FEATURE_MAP_NUM) from an upstream weight stream, then drives
//  the layer's level enable until it reports work_finished. Sits between the network-level
//  scheduler and C3S4_layer; owns kernel RAM write ports, layer_en, and a run watchdog.
// PARAMETERS
//  KERNEL_NUM       16     output kernels; kernel RAM rows per feature map
//  FEATURE_MAP_NUM  6      input feature maps = number of kernel RAMs
//  KRAM_AW          9      kernel RAM address width
//  KWORD_W          400    kernel word width (25 x 16-bit taps)
//  ARM_CYCLES       2      layer_en low gap between load end and run start (>=1)
//  TIMEOUT          20000  max RUN cycles before error
// PORTS
//  clk          in   1                 clock
//  rst_n        in   1                 synchronous reset, active low
//  start        in   1                 1-cycle request to run the layer
//  reload       in   1                 sampled with start: 1 = reload kernels first
//  wt_valid     in   1                 weight word valid
//  wt_ready     out  1                 weight word accepted when valid & ready
//  wt_data      in   KWORD_W           one kernel word (one kernel x one feature map)
//  kram_addr    out  KRAM_AW           kernel RAM write address (= kernel index)
//  kram_data    out  KWORD_W           kernel RAM write data
//  kram_we      out  FEATURE_MAP_NUM   one-hot kernel RAM write enable
//  layer_en     out  1                 level enable to C3S4_layer
//  layer_fin    in   1                 work_finished pulse from C3S4_layer
//  busy         out  1                 high in every state except IDLE
//  done         out  1                 1-cycle pulse, layer completed
//  err          out  1                 sticky watchdog error, cleared by next accepted start
//  kernels_ok   out  1                 all KERNEL_NUM*FEATURE_MAP_NUM words loaded since reset
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; all outputs 0; counters 0; kernels_ok 0.
//   Reset mid-LOAD/RUN aborts immediately; partial load leaves kernels_ok 0.
//  States: IDLE, LOAD, ARM, RUN, DONE, ERR. All outputs registered.
//  IDLE: start=1 -> err<=0; if reload | !kernels_ok -> LOAD (k=0,f=0) else ARM.
//   start outside IDLE ignored (not queued).
//  LOAD: wt_ready=1 every cycle. Accept when wt_valid&wt_ready; next cycle kram_we=1<<f,
//   kram_addr=k, kram_data=captured word (1-cycle latency); kram_we=0 when nothing accepted.
//   Order: f increments 0..FEATURE_MAP_NUM-1, wraps to 0 and increments k. Accepting
//   (k=KERNEL_NUM-1, f=FEATURE_MAP_NUM-1): wt_ready drops next cycle, kernels_ok<=1, -> ARM;
//   final write still issues that cycle. Exactly KERNEL_NUM*FEATURE_MAP_NUM words per load.
//   kernels_ok<=0 on entry to LOAD.
//  ARM: layer_en=0 for ARM_CYCLES cycles (layer clears anchor/pool counters), then -> RUN.
//  RUN: layer_en=1; watchdog counts from 0. layer_fin=1 -> DONE (layer_en<=0). Counter
//   reaching TIMEOUT-1 without layer_fin -> ERR. layer_fin and timeout same cycle: fin wins.
//  DONE: done=1 for one cycle, layer_en=0, -> IDLE.
//  ERR: layer_en=0, err=1 (sticky), -> IDLE next cycle; done not pulsed.
//  layer_fin outside RUN ignored. busy=1 in LOAD/ARM/RUN/DONE/ERR.
//  Counter widths: k ceil(log2 KERNEL_NUM), f ceil(log2 FEATURE_MAP_NUM), watchdog 32 bit;
//   no counter overflows by construction.
// TESTING
//  T1 start+reload, 96 words back-to-back -> 96 writes, kram_we 6'h01..6'h20 per addr 0..15,
//   data matches; wt_ready low after word 96; layer_en rises 2 cycles after last write.
//  T2 load with wt_valid toggled 1/0 -> writes only on accepted words, order unchanged.
//  T3 layer_fin 500 cycles into RUN -> layer_en low next cycle, done=1 exactly 1 cycle, busy 0.
//  T4 second start, reload=0, kernels_ok=1 -> no LOAD, kram_we stays 0, straight to ARM.
//  T5 TIMEOUT=64, no layer_fin -> err=1, layer_en=0 at cycle 64, no done; next start clears err.
//  T6 rst_n=0 after 40 words -> all outputs 0 next cycle; start -> LOAD even with reload=0.

Source files
------------

// File: rtl/c3s4_layer_sequencer_if.sv
// c3s4_layer_sequencer_if: scheduler, weight-stream, kernel-RAM and layer signals of the C3S4 sequencer
// Ports (slave = sequencer view):
//   start, reload       in   run request, reload-kernels qualifier sampled with start
//   wt_valid, wt_data   in   upstream kernel word stream
//   wt_ready            out  kernel word accepted when wt_valid & wt_ready
//   kram_addr/data/we   out  kernel RAM write port, we one-hot per feature map
//   layer_en            out  level enable to C3S4_layer
//   layer_fin           in   work_finished pulse from C3S4_layer
//   busy, done, err     out  status: not idle, completion pulse, sticky watchdog error
//   kernels_ok          out  full kernel set loaded since reset
interface c3s4_layer_sequencer_if #(
    parameter int FEATURE_MAP_NUM = 6,
    parameter int KRAM_AW = 9,
    parameter int KWORD_W = 400
);
    logic start;
    logic reload;
    logic wt_valid;
    logic wt_ready;
    logic [KWORD_W-1:0] wt_data;
    logic [KRAM_AW-1:0] kram_addr;
    logic [KWORD_W-1:0] kram_data;
    logic [FEATURE_MAP_NUM-1:0] kram_we;
    logic layer_en;
    logic layer_fin;
    logic busy;
    logic done;
    logic err;
    logic kernels_ok;
    modport master(
        output start, reload, wt_valid, wt_data, layer_fin,
        input wt_ready, kram_addr, kram_data, kram_we, layer_en, busy, done, err, kernels_ok
    );
    modport slave(
        input start, reload, wt_valid, wt_data, layer_fin,
        output wt_ready, kram_addr, kram_data, kram_we, layer_en, busy, done, err, kernels_ok
    );
endinterface

// File: rtl/c3s4_layer_sequencer.sv
// c3s4_layer_sequencer: loads per-feature-map kernel RAMs from a weight stream, then runs the C3S4 layer under a watchdog
// Ports:
//   clk    in  clock
//   rst_n  in  synchronous reset, active low
//   bus    c3s4_layer_sequencer_if.slave (start/reload, weight stream, kernel RAM writes,
//          layer_en/layer_fin, busy/done/err/kernels_ok status)
module c3s4_layer_sequencer #(
    parameter int KERNEL_NUM = 16,
    parameter int FEATURE_MAP_NUM = 6,
    parameter int KRAM_AW = 9,
    parameter int KWORD_W = 400,
    parameter int ARM_CYCLES = 2,
    parameter int TIMEOUT = 20000
) (
    input logic clk,
    input logic rst_n,
    c3s4_layer_sequencer_if.slave bus
);
    localparam int KW = KERNEL_NUM > 1 ? $clog2(KERNEL_NUM) : 1;
    localparam int FW = FEATURE_MAP_NUM > 1 ? $clog2(FEATURE_MAP_NUM) : 1;
    localparam int AW = ARM_CYCLES > 1 ? $clog2(ARM_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DONE, ERR} state_t;
    state_t state;
    logic [KW-1:0] k;
    logic [FW-1:0] f;
    logic [AW-1:0] arm_cnt;
    logic [31:0] wd;
    logic last_k, last_f;
    assign last_k = k == KW'(KERNEL_NUM - 1);
    assign last_f = f == FW'(FEATURE_MAP_NUM - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            k <= '0;
            f <= '0;
            arm_cnt <= '0;
            wd <= '0;
            bus.wt_ready <= 1'b0;
            bus.kram_addr <= '0;
            bus.kram_data <= '0;
            bus.kram_we <= '0;
            bus.layer_en <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err <= 1'b0;
            bus.kernels_ok <= 1'b0;
        end else begin
            bus.kram_we <= '0;
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bus.err <= 1'b0;
                    bus.busy <= 1'b1;
                    arm_cnt <= '0;
                    if (bus.reload || !bus.kernels_ok) begin
                        state <= LOAD;
                        k <= '0;
                        f <= '0;
                        bus.wt_ready <= 1'b1;
                        bus.kernels_ok <= 1'b0;
                    end else begin
                        state <= ARM;
                    end
                end
                // wt_ready is held high throughout LOAD, so valid alone means accepted;
                // the write lands one cycle after acceptance from the captured word.
                LOAD: if (bus.wt_valid) begin
                    bus.kram_we <= {{(FEATURE_MAP_NUM-1){1'b0}}, 1'b1} << f;
                    bus.kram_addr <= KRAM_AW'(k);
                    bus.kram_data <= bus.wt_data;
                    f <= last_f ? '0 : f + FW'(1);
                    k <= last_f && !last_k ? k + KW'(1) : k;
                    if (last_f && last_k) begin
                        state <= ARM;
                        bus.wt_ready <= 1'b0;
                        bus.kernels_ok <= 1'b1;
                    end
                end
                ARM: if (arm_cnt == AW'(ARM_CYCLES - 1)) begin
                    state <= RUN;
                    bus.layer_en <= 1'b1;
                    wd <= '0;
                end else begin
                    arm_cnt <= arm_cnt + AW'(1);
                end
                // layer_fin is checked first so a finish on the last allowed cycle still completes.
                RUN: if (bus.layer_fin) begin
                    state <= DONE;
                    bus.layer_en <= 1'b0;
                    bus.done <= 1'b1;
                end else if (wd == 32'(TIMEOUT - 1)) begin
                    state <= ERR;
                    bus.layer_en <= 1'b0;
                    bus.err <= 1'b1;
                end else begin
                    wd <= wd + 32'd1;
                end
                DONE, ERR: begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c3s4_layer_sequencer.sv
// tb_c3s4_layer_sequencer: randomized bench for c3s4_layer_sequencer against a count-based behavioural model
`timescale 1ns/1ps
module tb_c3s4_layer_sequencer;
    localparam int KN = 16;
    localparam int FN = 6;
    localparam int AWD = 9;
    localparam int KWW = 400;
    localparam int ARMC = 2;
    localparam int TO = 640;
    localparam int NW = KN * FN;
    localparam int M_IDLE = 0, M_LOAD = 1, M_ARM = 2, M_RUN = 3, M_DONE = 4, M_ERR = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    c3s4_layer_sequencer_if #(.FEATURE_MAP_NUM(FN), .KRAM_AW(AWD), .KWORD_W(KWW)) bus();
    c3s4_layer_sequencer #(
        .KERNEL_NUM(KN), .FEATURE_MAP_NUM(FN), .KRAM_AW(AWD), .KWORD_W(KWW),
        .ARM_CYCLES(ARMC), .TIMEOUT(TO)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string name, input logic [KWW-1:0] act, input logic [KWW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: phases plus a running accepted-word count n; the write target
    // of word n is feature map n%FN of kernel n/FN.
    int m_mode = M_IDLE, m_n = 0, m_arm = 0, m_t = 0;
    bit m_ok = 0, m_err = 0, m_valid = 0;
    logic [FN-1:0] m_we = '0;
    logic [AWD-1:0] m_addr = '0;
    logic [KWW-1:0] m_data = '0;

    always @(posedge clk) begin
        m_we = '0;
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_ok = 0;
            m_err = 0;
            m_addr = '0;
            m_data = '0;
            m_valid = 1;
        end else if (m_mode == M_IDLE) begin
            if (bus.start) begin
                m_err = 0;
                if (bus.reload || !m_ok) begin
                    m_mode = M_LOAD;
                    m_n = 0;
                    m_ok = 0;
                end else begin
                    m_mode = M_ARM;
                    m_arm = 0;
                end
            end
        end else if (m_mode == M_LOAD) begin
            if (bus.wt_valid) begin
                m_we[m_n % FN] = 1'b1;
                m_addr = AWD'(m_n / FN);
                m_data = bus.wt_data;
                m_n++;
                if (m_n == NW) begin
                    m_ok = 1;
                    m_mode = M_ARM;
                    m_arm = 0;
                end
            end
        end else if (m_mode == M_ARM) begin
            m_arm++;
            if (m_arm == ARMC) begin
                m_mode = M_RUN;
                m_t = 0;
            end
        end else if (m_mode == M_RUN) begin
            m_t++;
            if (bus.layer_fin) m_mode = M_DONE;
            else if (m_t == TO) begin
                m_mode = M_ERR;
                m_err = 1;
            end
        end else begin
            m_mode = M_IDLE;
        end
    end

    logic [FN-1:0] wr_we[$];
    logic [AWD-1:0] wr_addr[$];
    logic [KWW-1:0] wr_data[$];
    int wr_cyc[$];
    int en_rise = 0, en_cnt = 0, done_cnt = 0;
    bit en_q = 0;

    always @(negedge clk) begin
        cyc++;
        if (m_valid) begin
            chk("wt_ready", int'(bus.wt_ready), int'(m_mode == M_LOAD));
            chk("busy", int'(bus.busy), int'(m_mode != M_IDLE));
            chk("layer_en", int'(bus.layer_en), int'(m_mode == M_RUN));
            chk("done", int'(bus.done), int'(m_mode == M_DONE));
            chk("err", int'(bus.err), int'(m_err));
            chk("kernels_ok", int'(bus.kernels_ok), int'(m_ok));
            chk("kram_we", int'(bus.kram_we), int'(m_we));
            if (m_we != '0) begin
                chk("kram_addr", int'(bus.kram_addr), int'(m_addr));
                chkw("kram_data", bus.kram_data, m_data);
            end
        end
        if (bus.kram_we != '0) begin
            wr_we.push_back(bus.kram_we);
            wr_addr.push_back(bus.kram_addr);
            wr_data.push_back(bus.kram_data);
            wr_cyc.push_back(cyc);
        end
        if (bus.layer_en && !en_q) en_rise = cyc;
        en_q = bus.layer_en;
        en_cnt += int'(bus.layer_en);
        done_cnt += int'(bus.done);
    end

    function automatic logic [KWW-1:0] rnd_word();
        logic [KWW-1:0] w = '0;
        for (int i = 0; i < (KWW + 31) / 32; i++) w = {w[KWW-33:0], $urandom()};
        return w;
    endfunction

    logic [KWW-1:0] last_word;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit r);
        bus.start = 1'b1;
        bus.reload = r;
        tick();
        bus.start = 1'b0;
        bus.reload = 1'($urandom_range(1));
    endtask

    // Streams words while wt_ready is high, with stray start/layer_fin pulses that must be ignored.
    task automatic load(input int pct, input bit alt, input int stop_at);
        int acc = 0;
        int g = 0;
        bit ph = 0;
        while (bus.wt_ready && acc < stop_at && g < 4000) begin
            ph = !ph;
            bus.wt_valid = alt ? ph : (int'($urandom_range(99)) < pct);
            bus.wt_data = rnd_word();
            bus.start = ($urandom_range(15) == 0);
            bus.layer_fin = ($urandom_range(15) == 0);
            if (bus.wt_valid) begin
                acc++;
                last_word = bus.wt_data;
            end
            tick();
            g++;
        end
        bus.wt_valid = 1'b0;
        bus.start = 1'b0;
        bus.layer_fin = 1'b0;
        chk("load_bounded", int'(g < 4000), 1);
    endtask

    // Waits for layer_en, pulses layer_fin in RUN cycle d (d<0: never), then waits for idle.
    task automatic run(input int d);
        int g = 0;
        while (!bus.layer_en && g < 10) begin
            tick();
            g++;
        end
        chk("layer_en_rise", int'(bus.layer_en), 1);
        if (d >= 0) begin
            repeat (d) tick();
            bus.layer_fin = 1'b1;
            tick();
            bus.layer_fin = 1'b0;
        end
        g = 0;
        while (bus.busy && g < TO + 20) begin
            tick();
            g++;
        end
        chk("idle_after_run", int'(bus.busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, d0, e0;
        bus.start = 1'b0;
        bus.reload = 1'b0;
        bus.wt_valid = 1'b0;
        bus.wt_data = '0;
        bus.layer_fin = 1'b0;
        last_word = '0;
        repeat (3) tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_we", int'(bus.kram_we), 0);
        chk("rst_addr", int'(bus.kram_addr), 0);
        chkw("rst_data", bus.kram_data, '0);
        chk("rst_ok", int'(bus.kernels_ok), 0);
        rst_n = 1'b1;
        tick();

        base = wr_we.size();
        d0 = done_cnt;
        e0 = en_cnt;
        pulse_start(1'b1);
        load(100, 1'b0, NW);
        chk("t1_ready_low", int'(bus.wt_ready), 0);
        chk("t1_kernels_ok", int'(bus.kernels_ok), 1);
        run(499);
        chk("t1_writes", wr_we.size() - base, NW);
        chk("t1_we_first", int'(wr_we[base]), 'h01);
        chk("t1_we_sixth", int'(wr_we[base+5]), 'h20);
        chk("t1_addr_seventh", int'(wr_addr[base+6]), 1);
        chk("t1_addr_last", int'(wr_addr[base+NW-1]), 15);
        chkw("t1_data_last", wr_data[base+NW-1], last_word);
        chk("t1_en_gap", en_rise - wr_cyc[base+NW-1], 2);
        chk("t3_en_cycles", en_cnt - e0, 500);
        chk("t3_done_once", done_cnt - d0, 1);

        base = wr_we.size();
        d0 = done_cnt;
        pulse_start(1'b0);
        chk("t4_no_load", int'(bus.wt_ready), 0);
        run(int'($urandom_range(10, 100)));
        chk("t4_writes", wr_we.size() - base, 0);
        chk("t4_done", done_cnt - d0, 1);

        base = wr_we.size();
        pulse_start(1'b1);
        load(0, 1'b1, NW);
        run(int'($urandom_range(0, 50)));
        chk("t2_writes", wr_we.size() - base, NW);

        d0 = done_cnt;
        e0 = en_cnt;
        pulse_start(1'b0);
        run(-1);
        chk("t5_en_cycles", en_cnt - e0, TO);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_err", int'(bus.err), 1);
        pulse_start(1'b0);
        chk("t5_err_cleared", int'(bus.err), 0);
        d0 = done_cnt;
        run(TO - 1);
        chk("fin_at_limit_done", done_cnt - d0, 1);
        chk("fin_at_limit_err", int'(bus.err), 0);
        pulse_start(1'b0);
        run(TO);
        chk("fin_late_err", int'(bus.err), 1);

        pulse_start(1'b1);
        load(100, 1'b0, 40);
        rst_n = 1'b0;
        tick();
        chk("t6_busy", int'(bus.busy), 0);
        chk("t6_ready", int'(bus.wt_ready), 0);
        chk("t6_we", int'(bus.kram_we), 0);
        chk("t6_ok", int'(bus.kernels_ok), 0);
        chk("t6_err", int'(bus.err), 0);
        rst_n = 1'b1;
        tick();
        pulse_start(1'b0);
        chk("t6_reload_forced", int'(bus.wt_ready), 1);
        load(70, 1'b0, NW);
        run(int'($urandom_range(0, 200)));

        for (int s = 0; s < 8; s++) begin
            pulse_start(1'($urandom_range(1)));
            if (bus.wt_ready) load(int'($urandom_range(30, 100)), 1'b0, NW);
            run($urandom_range(3) == 0 ? -1 : int'($urandom_range(0, TO + 5)));
            repeat (int'($urandom_range(0, 3))) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
